// File: rtl/einstein_int_pkg.sv
// Shared constants, state encodings and arbitration helpers for the Einstein
// mode-2 interrupt controller.
package einstein_int_pkg;

  localparam logic [1:0] SRC_KB   = 2'd0;
  localparam logic [1:0] SRC_FIRE = 2'd1;
  localparam logic [1:0] SRC_ADC  = 2'd2;
  localparam logic [1:0] SRC_EXT  = 2'd3;

  localparam logic [7:0] VEC_BASE = 8'h08;
  localparam logic [7:0] OP_ED    = 8'hED;
  localparam logic [7:0] OP_RETI2 = 8'h4D;

  typedef enum logic [1:0] {ST_IDLE, ST_ACK, ST_SPUR} main_state_t;
  typedef enum logic {R_IDLE, R_ED} reti_state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } src_sel_t;

  // Highest-priority set bit: ADC > fire > keyboard > expansion.
  function automatic src_sel_t pick_top(input logic [3:0] v);
    src_sel_t s;
    s.valid = |v;
    if (v[SRC_ADC])       s.idx = SRC_ADC;
    else if (v[SRC_FIRE]) s.idx = SRC_FIRE;
    else if (v[SRC_KB])   s.idx = SRC_KB;
    else                  s.idx = SRC_EXT;
    return s;
  endfunction

  function automatic logic [1:0] prio_lvl(input logic [1:0] idx);
    logic [1:0] lvl;
    case (idx)
      SRC_ADC:  lvl = 2'd3;
      SRC_FIRE: lvl = 2'd2;
      SRC_KB:   lvl = 2'd1;
      default:  lvl = 2'd0;
    endcase
    return lvl;
  endfunction

  function automatic logic [7:0] vec_of(input logic [1:0] idx);
    logic [1:0] rank;
    rank = 2'd3 - idx;
    return VEC_BASE + {5'b00000, rank, 1'b0};
  endfunction

endpackage

// File: rtl/einstein_reti_detect.sv
// Watches CPU opcode fetches for the ED 4D (RETI) sequence and emits a
// single-cycle reti pulse on the clock the 4D fetch ends.
//
// state  | meaning
// R_IDLE | no prefix seen
// R_ED   | last completed fetch was ED
module einstein_reti_detect
  import einstein_int_pkg::*;
(
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       m1_n,
  input  logic       mreq_n,
  input  logic       rd_n,
  input  logic [7:0] opcode,
  output logic       reti
);

  reti_state_t state_q, state_d;
  logic        fetch, fetch_q, fetch_end;
  logic [7:0]  op_q;

  assign fetch     = ~m1_n & ~mreq_n & ~rd_n;
  assign fetch_end = fetch_q & ~fetch;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= R_IDLE;
      fetch_q <= 1'b0;
      op_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      fetch_q <= fetch;
      if (fetch) op_q <= opcode;
    end
  end

  always_comb begin
    state_d = state_q;
    reti    = 1'b0;
    if (fetch_end) begin
      if (op_q == OP_ED) begin
        state_d = R_ED;
      end else begin
        state_d = R_IDLE;
        reti    = (state_q == R_ED) && (op_q == OP_RETI2);
      end
    end
  end

endmodule

// File: rtl/einstein_int_ctrl.sv
// Z80 mode-2 interrupt controller: masks and arbitrates four sources, drives
// /INT, serves the vector during INTA and tracks nested in-service levels.
//
// state   | meaning
// ST_IDLE | waiting; /INT reflects the eligible winner
// ST_ACK  | INTA in progress, vector driven onto data-in
// ST_SPUR | INTA with nothing eligible, bus left alone
module einstein_int_ctrl
  import einstein_int_pkg::*;
#(
  parameter logic [3:0] MASK_RESET = 4'h0
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [3:0] int_req_n,
  input  logic       m1_n,
  input  logic       iorq_n,
  input  logic       mreq_n,
  input  logic       rd_n,
  input  logic [7:0] opcode,
  input  logic       mask_we,
  input  logic [3:0] mask_din,
  output logic       int_n,
  output logic       vec_oe,
  output logic [7:0] vec_dout,
  output logic [3:0] in_service,
  output logic [3:0] mask_q
);

  main_state_t state_q, state_d;
  logic [1:0]  ack_idx_q, ack_idx_d;
  logic [3:0]  pend_q;
  logic [3:0]  in_service_d, set_vec, clr_vec;
  logic        int_n_d, vec_oe_d;
  logic [7:0]  vec_dout_d;
  logic        inta, reti, eligible;
  src_sel_t    win, blk, isr_top;

  einstein_reti_detect u_reti (
    .clk_sys (clk_sys),
    .reset   (reset),
    .m1_n    (m1_n),
    .mreq_n  (mreq_n),
    .rd_n    (rd_n),
    .opcode  (opcode),
    .reti    (reti)
  );

  assign inta = ~m1_n & ~iorq_n;

  // RETI clear is applied before the ACK set so a same-cycle pair nests correctly.
  always_comb begin
    isr_top = pick_top(in_service);
    clr_vec = 4'b0000;
    set_vec = 4'b0000;
    if (reti && isr_top.valid)
      clr_vec[isr_top.idx] = 1'b1;
    if (state_q == ST_ACK && !inta)
      set_vec[ack_idx_q] = 1'b1;
    in_service_d = (in_service & ~clr_vec) | set_vec;
    win      = pick_top(pend_q);
    blk      = pick_top(in_service_d);
    eligible = win.valid && (!blk.valid || (prio_lvl(win.idx) > prio_lvl(blk.idx)));
  end

  always_comb begin
    state_d    = state_q;
    ack_idx_d  = ack_idx_q;
    vec_dout_d = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (inta) begin
          ack_idx_d = win.idx;
          if (eligible) begin
            state_d    = ST_ACK;
            vec_dout_d = vec_of(win.idx);
          end else begin
            state_d = ST_SPUR;
          end
        end
      end
      ST_ACK: begin
        vec_dout_d = vec_dout;
        if (!inta) state_d = ST_IDLE;
      end
      ST_SPUR: begin
        if (!inta) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    vec_oe_d = (state_d == ST_ACK);
    int_n_d  = !((state_d == ST_IDLE) && eligible);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ack_idx_q  <= SRC_KB;
      pend_q     <= 4'b0000;
      in_service <= 4'b0000;
      mask_q     <= MASK_RESET;
      int_n      <= 1'b1;
      vec_oe     <= 1'b0;
      vec_dout   <= 8'h00;
    end else begin
      state_q    <= state_d;
      ack_idx_q  <= ack_idx_d;
      pend_q     <= ~int_req_n & ~mask_q;
      in_service <= in_service_d;
      if (mask_we) mask_q <= mask_din;
      int_n      <= int_n_d;
      vec_oe     <= vec_oe_d;
      vec_dout   <= vec_dout_d;
    end
  end

endmodule

// File: tb/tb_einstein_int_ctrl.sv
// Directed bench for einstein_int_ctrl: one task per scenario, inline checks
// against hand-computed vectors, interrupt latencies and in-service states.
module tb_einstein_int_ctrl;

  logic       clk_sys = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] int_req_n = 4'hF;
  logic       m1_n = 1'b1, iorq_n = 1'b1, mreq_n = 1'b1, rd_n = 1'b1;
  logic [7:0] opcode = 8'h00;
  logic       mask_we = 1'b0;
  logic [3:0] mask_din = 4'h0;
  logic       int_n, vec_oe;
  logic [7:0] vec_dout;
  logic [3:0] in_service, mask_q;

  int n_cmp = 0;
  int n_err = 0;

  einstein_int_ctrl #(.MASK_RESET(4'h0)) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .int_req_n  (int_req_n),
    .m1_n       (m1_n),
    .iorq_n     (iorq_n),
    .mreq_n     (mreq_n),
    .rd_n       (rd_n),
    .opcode     (opcode),
    .mask_we    (mask_we),
    .mask_din   (mask_din),
    .int_n      (int_n),
    .vec_oe     (vec_oe),
    .vec_dout   (vec_dout),
    .in_service (in_service),
    .mask_q     (mask_q)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic inta_start();
    m1_n = 1'b0; iorq_n = 1'b0;
    tick();
  endtask

  task automatic inta_end();
    m1_n = 1'b1; iorq_n = 1'b1;
    tick();
  endtask

  task automatic fetch(input logic [7:0] op);
    m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0; opcode = op;
    tick(2);
    m1_n = 1'b1; mreq_n = 1'b1; rd_n = 1'b1; opcode = 8'h00;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(2);
    n_cmp++; if (int_n !== 1'b1) begin n_err++; $display("FAIL rst_int_n got %b want 1", int_n); end
    n_cmp++; if (vec_oe !== 1'b0) begin n_err++; $display("FAIL rst_vec_oe got %b want 0", vec_oe); end
    n_cmp++; if (vec_dout !== 8'h00) begin n_err++; $display("FAIL rst_vec_dout got %h want 00", vec_dout); end
    n_cmp++; if (in_service !== 4'b0000) begin n_err++; $display("FAIL rst_in_service got %b want 0000", in_service); end
    n_cmp++; if (mask_q !== 4'h0) begin n_err++; $display("FAIL rst_mask_q got %b want 0000", mask_q); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_kb();
    int_req_n = 4'b1110;
    tick();
    n_cmp++; if (int_n !== 1'b1) begin n_err++; $display("FAIL kb_lat1 int_n got %b want 1", int_n); end
    tick();
    n_cmp++; if (int_n !== 1'b0) begin n_err++; $display("FAIL kb_lat2 int_n got %b want 0", int_n); end
    inta_start();
    n_cmp++; if (vec_oe !== 1'b1) begin n_err++; $display("FAIL kb_vec_oe got %b want 1", vec_oe); end
    n_cmp++; if (vec_dout !== 8'h0E) begin n_err++; $display("FAIL kb_vec got %h want 0e", vec_dout); end
    n_cmp++; if (int_n !== 1'b1) begin n_err++; $display("FAIL kb_ack_int_n got %b want 1", int_n); end
    tick();
    n_cmp++; if (vec_dout !== 8'h0E) begin n_err++; $display("FAIL kb_vec_hold got %h want 0e", vec_dout); end
    inta_end();
    n_cmp++; if (in_service !== 4'b0001) begin n_err++; $display("FAIL kb_isr got %b want 0001", in_service); end
    n_cmp++; if (vec_oe !== 1'b0) begin n_err++; $display("FAIL kb_vec_oe_off got %b want 0", vec_oe); end
    tick();
    n_cmp++; if (int_n !== 1'b1) begin n_err++; $display("FAIL kb_self_block got %b want 1", int_n); end
    int_req_n = 4'hF;
    fetch(8'hED);
    fetch(8'h4D);
    n_cmp++; if (in_service !== 4'b0000) begin n_err++; $display("FAIL kb_reti got %b want 0000", in_service); end
  endtask

  task automatic test_priority();
    int_req_n = 4'b1010;
    tick(2);
    n_cmp++; if (int_n !== 1'b0) begin n_err++; $display("FAIL pri_int_n got %b want 0", int_n); end
    inta_start();
    n_cmp++; if (vec_dout !== 8'h0A) begin n_err++; $display("FAIL pri_vec got %h want 0a", vec_dout); end
    int_req_n = 4'b1110;
    tick();
    n_cmp++; if (vec_dout !== 8'h0A) begin n_err++; $display("FAIL pri_vec_frozen got %h want 0a", vec_dout); end
    inta_end();
    n_cmp++; if (in_service !== 4'b0100) begin n_err++; $display("FAIL pri_isr got %b want 0100", in_service); end
    n_cmp++; if (int_n !== 1'b1) begin n_err++; $display("FAIL pri_kb_blocked got %b want 1", int_n); end
    int_req_n = 4'hF;
    fetch(8'hED);
    fetch(8'h4D);
    n_cmp++; if (in_service !== 4'b0000) begin n_err++; $display("FAIL pri_reti got %b want 0000", in_service); end
  endtask

  task automatic test_nesting();
    int_req_n = 4'b1110;
    tick(2);
    inta_start();
    n_cmp++; if (vec_dout !== 8'h0E) begin n_err++; $display("FAIL nest_kb_vec got %h want 0e", vec_dout); end
    int_req_n = 4'hF;
    inta_end();
    int_req_n = 4'b1101;
    tick(2);
    n_cmp++; if (int_n !== 1'b0) begin n_err++; $display("FAIL nest_fire_int_n got %b want 0", int_n); end
    inta_start();
    n_cmp++; if (vec_dout !== 8'h0C) begin n_err++; $display("FAIL nest_fire_vec got %h want 0c", vec_dout); end
    int_req_n = 4'hF;
    inta_end();
    n_cmp++; if (in_service !== 4'b0011) begin n_err++; $display("FAIL nest_isr got %b want 0011", in_service); end
    fetch(8'hED);
    fetch(8'h4D);
    n_cmp++; if (in_service !== 4'b0001) begin n_err++; $display("FAIL nest_reti1 got %b want 0001", in_service); end
    int_req_n = 4'b1110;
    tick(2);
    n_cmp++; if (int_n !== 1'b1) begin n_err++; $display("FAIL nest_kb_blocked got %b want 1", int_n); end
    fetch(8'hED);
    n_cmp++; if (int_n !== 1'b1) begin n_err++; $display("FAIL nest_kb_blocked_ed got %b want 1", int_n); end
    fetch(8'h4D);
    n_cmp++; if (in_service !== 4'b0000) begin n_err++; $display("FAIL nest_reti2 got %b want 0000", in_service); end
    n_cmp++; if (int_n !== 1'b0) begin n_err++; $display("FAIL nest_kb_release got %b want 0", int_n); end
    int_req_n = 4'hF;
    tick(2);
    n_cmp++; if (int_n !== 1'b1) begin n_err++; $display("FAIL nest_drop got %b want 1", int_n); end
  endtask

  task automatic test_masking();
    mask_din = 4'b0100; mask_we = 1'b1;
    tick();
    mask_we = 1'b0;
    n_cmp++; if (mask_q !== 4'b0100) begin n_err++; $display("FAIL mask_write got %b want 0100", mask_q); end
    int_req_n = 4'b1011;
    tick(3);
    n_cmp++; if (int_n !== 1'b1) begin n_err++; $display("FAIL mask_hold got %b want 1", int_n); end
    mask_din = 4'b0000; mask_we = 1'b1;
    tick();
    mask_we = 1'b0;
    n_cmp++; if (int_n !== 1'b1) begin n_err++; $display("FAIL unmask_lat0 got %b want 1", int_n); end
    tick();
    n_cmp++; if (int_n !== 1'b1) begin n_err++; $display("FAIL unmask_lat1 got %b want 1", int_n); end
    tick();
    n_cmp++; if (int_n !== 1'b0) begin n_err++; $display("FAIL unmask_lat2 got %b want 0", int_n); end
    mask_din = 4'b0100; mask_we = 1'b1; m1_n = 1'b0; iorq_n = 1'b0;
    tick();
    mask_we = 1'b0;
    n_cmp++; if (vec_oe !== 1'b1) begin n_err++; $display("FAIL mask_inta_oe got %b want 1", vec_oe); end
    n_cmp++; if (vec_dout !== 8'h0A) begin n_err++; $display("FAIL mask_inta_vec got %h want 0a", vec_dout); end
    int_req_n = 4'hF;
    inta_end();
    n_cmp++; if (in_service !== 4'b0100) begin n_err++; $display("FAIL mask_keeps_isr got %b want 0100", in_service); end
    fetch(8'hED);
    fetch(8'h4D);
    n_cmp++; if (in_service !== 4'b0000) begin n_err++; $display("FAIL mask_reti got %b want 0000", in_service); end
    mask_din = 4'b0000; mask_we = 1'b1;
    tick();
    mask_we = 1'b0;
  endtask

  task automatic test_spurious();
    int_req_n = 4'b1110;
    tick(2);
    inta_start();
    int_req_n = 4'hF;
    inta_end();
    tick(2);
    inta_start();
    n_cmp++; if (vec_oe !== 1'b0) begin n_err++; $display("FAIL spur_vec_oe got %b want 0", vec_oe); end
    n_cmp++; if (int_n !== 1'b1) begin n_err++; $display("FAIL spur_int_n got %b want 1", int_n); end
    inta_end();
    n_cmp++; if (in_service !== 4'b0001) begin n_err++; $display("FAIL spur_isr got %b want 0001", in_service); end
    fetch(8'hED);
    fetch(8'h00);
    fetch(8'h4D);
    n_cmp++; if (in_service !== 4'b0001) begin n_err++; $display("FAIL broken_reti got %b want 0001", in_service); end
    fetch(8'hED);
    fetch(8'hED);
    fetch(8'h4D);
    n_cmp++; if (in_service !== 4'b0000) begin n_err++; $display("FAIL ed_ed_reti got %b want 0000", in_service); end
  endtask

  task automatic test_reset_mid_ack();
    mask_din = 4'b1000; mask_we = 1'b1;
    tick();
    mask_we = 1'b0;
    int_req_n = 4'b1110;
    tick(2);
    inta_start();
    n_cmp++; if (vec_oe !== 1'b1) begin n_err++; $display("FAIL rack_pre_oe got %b want 1", vec_oe); end
    reset = 1'b1;
    tick();
    n_cmp++; if (vec_oe !== 1'b0) begin n_err++; $display("FAIL rack_vec_oe got %b want 0", vec_oe); end
    n_cmp++; if (int_n !== 1'b1) begin n_err++; $display("FAIL rack_int_n got %b want 1", int_n); end
    n_cmp++; if (in_service !== 4'b0000) begin n_err++; $display("FAIL rack_isr got %b want 0000", in_service); end
    n_cmp++; if (mask_q !== 4'h0) begin n_err++; $display("FAIL rack_mask got %b want 0000", mask_q); end
    int_req_n = 4'hF; m1_n = 1'b1; iorq_n = 1'b1;
    tick();
    reset = 1'b0;
    tick(3);
    n_cmp++; if (in_service !== 4'b0000) begin n_err++; $display("FAIL rack_no_record got %b want 0000", in_service); end
  endtask

  initial begin
    test_reset();
    test_single_kb();
    test_priority();
    test_nesting();
    test_masking();
    test_spurious();
    test_reset_mid_ack();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
